// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts outstanding rd writes per register, stalls decode on
// RAW hazards or counter saturation, and sequences pipeline drain requests.
module reg_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int DEPTHMSB = $clog2(DEPTH) - 1,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [1:0]                id_re,
  input  logic [2*(DEPTHMSB+1)-1:0] id_ra,
  input  logic                      id_we,
  input  logic [DEPTHMSB:0]         id_wd_addr,
  input  logic                      id_flush,
  output logic                      id_ready,
  input  logic                      wb_valid,
  input  logic [DEPTHMSB:0]         wb_addr,
  input  logic                      kill_valid,
  input  logic [DEPTHMSB:0]         kill_addr,
  input  logic                      drain_req,
  output logic                      drain_ack,
  output logic [DEPTH-1:0]          pend,
  output logic                      busy,
  output logic                      err
);
  // state  | meaning
  // IDLE   | normal issue
  // DRAIN  | issue blocked, waiting for every pending write to retire
  // ACK    | scoreboard empty, drain_ack asserted for this cycle
  // WAIT   | holding until drain_req is released
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ACK, S_WAIT} state_t;

  localparam int AW = DEPTHMSB + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [DEPTH];
  logic [CNT_W-1:0] cnt_nxt [DEPTH];
  logic [DEPTH-1:0] eff_nz;
  logic [DEPTH-1:0] uflow;
  logic [AW-1:0]    ra0, ra1;
  logic             raw, sat, issue, all_empty;

  assign ra0 = id_ra[AW-1:0];
  assign ra1 = id_ra[2*AW-1:AW];

  assign raw = (id_re[0] && (ra0 != '0) && eff_nz[ra0]) ||
               (id_re[1] && (ra1 != '0) && eff_nz[ra1]);
  assign sat = id_we && (id_wd_addr != '0) && (cnt[id_wd_addr] == {CNT_W{1'b1}});

  assign id_ready  = ~raw & ~sat & (state == S_IDLE) & ~drain_req;
  assign issue     = id_valid & id_ready & ~id_flush;
  assign all_empty = ~|eff_nz;

  // Per-register next count; eff_nz sees same-cycle retirements so writeback bypasses.
  always_comb begin
    int unsigned c_i, d_i, u_i;
    for (int r = 0; r < DEPTH; r++) begin
      c_i = int'(cnt[r]);
      d_i = 0;
      u_i = c_i;
      if (r != 0) begin
        if (wb_valid && (wb_addr == AW'(r)))                   d_i = d_i + 1;
        if (kill_valid && (kill_addr == AW'(r)))               d_i = d_i + 1;
        if (issue && id_we && (id_wd_addr == AW'(r)))          u_i = u_i + 1;
      end
      eff_nz[r] = (c_i > d_i);
      uflow[r]  = 1'b0;
      if (u_i < d_i) begin
        cnt_nxt[r] = '0;
        uflow[r]   = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(u_i - d_i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      err   <= 1'b0;
      state <= S_IDLE;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
      err   <= err | (|uflow);
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_ack = 1'b0;
    case (state)
      S_IDLE:  if (drain_req) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!drain_req)     state_nxt = S_IDLE;
        else if (all_empty) state_nxt = S_ACK;
      end
      S_ACK: begin
        drain_ack = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (!drain_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) pend[r] = |cnt[r];
  end

  assign busy = |pend;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, saturation, retire arithmetic and drain.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_re;
  logic [9:0]  id_ra;
  logic        id_we;
  logic [4:0]  id_wd_addr;
  logic        id_flush;
  logic        id_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        kill_valid;
  logic [4:0]  kill_addr;
  logic        drain_req;
  logic        drain_ack;
  logic [31:0] pend;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_re(id_re), .id_ra(id_ra),
    .id_we(id_we), .id_wd_addr(id_wd_addr), .id_flush(id_flush), .id_ready(id_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .kill_valid(kill_valid), .kill_addr(kill_addr),
    .drain_req(drain_req), .drain_ack(drain_ack), .pend(pend), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_re = 0; id_ra = 0; id_we = 0; id_wd_addr = 0; id_flush = 0;
    wb_valid = 0; wb_addr = 0; kill_valid = 0; kill_addr = 0; drain_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    // reset with random traffic (drain_req kept low so id_ready must be 1)
    repeat (6) begin
      id_valid = 1'($urandom); id_re = 2'($urandom); id_ra = 10'($urandom);
      id_we = 1'($urandom); id_wd_addr = 5'($urandom); id_flush = 1'($urandom);
      wb_valid = 1'($urandom); wb_addr = 5'($urandom);
      kill_valid = 1'($urandom); kill_addr = 5'($urandom);
      #1;
      chk("rst_ready", id_ready, 1);
      chk("rst_pend", pend, 0);
      chk("rst_err", err, 0);
      chk("rst_ack", drain_ack, 0);
      @(posedge clk);
    end
    clr();
    @(negedge clk);
    rst = 1'b1;
    step();

    // RAW on port 0, cleared by same-cycle writeback
    id_valid = 1; id_we = 1; id_wd_addr = 5;
    #1 chk("raw_issue_rdy", id_ready, 1);
    step();
    clr(); id_valid = 1; id_re = 2'b01; id_ra = {5'd0, 5'd5};
    #1 chk("raw_stall", id_ready, 0);
    chk("raw_pend5", pend[5], 1);
    step();
    chk("raw_stall2", id_ready, 0);
    wb_valid = 1; wb_addr = 5;
    #1 chk("raw_wb_bypass", id_ready, 1);
    step(); clr();
    #1 chk("raw_pend5_clr", pend[5], 0);
    chk("raw_busy_clr", busy, 0);

    // RAW on port 1, cleared by same-cycle kill
    id_valid = 1; id_we = 1; id_wd_addr = 12;
    step(); clr();
    id_valid = 1; id_re = 2'b10; id_ra = {5'd12, 5'd0};
    #1 chk("raw1_stall", id_ready, 0);
    kill_valid = 1; kill_addr = 12;
    #1 chk("kill_bypass", id_ready, 1);
    step(); clr();
    #1 chk("kill_busy", busy, 0);
    chk("kill_err", err, 0);

    // WAW saturation on x7
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_we = 1; id_wd_addr = 7;
      #1 chk("sat_issue_rdy", id_ready, 1);
      step();
    end
    chk("sat_stall", id_ready, 0);
    chk("sat_cnt3", 32'(dut.cnt[7]), 3);
    step();
    chk("sat_hold", 32'(dut.cnt[7]), 3);
    wb_valid = 1; wb_addr = 7;
    #1 chk("sat_wb_stall", id_ready, 0);
    step();
    wb_valid = 0;
    #1 chk("sat_release", id_ready, 1);
    step();
    chk("sat_cnt_back3", 32'(dut.cnt[7]), 3);
    clr(); wb_valid = 1; wb_addr = 7;
    repeat (3) step();
    clr();
    #1 chk("sat_pend7_clr", pend[7], 0);

    // x0 never tracked, flushed issue never counts
    id_valid = 1; id_we = 1; id_wd_addr = 0;
    #1 chk("x0_rdy", id_ready, 1);
    step();
    id_wd_addr = 4; id_flush = 1;
    step(); clr();
    id_valid = 1; id_re = 2'b11; id_ra = 10'd0;
    wb_valid = 1; wb_addr = 0; kill_valid = 1; kill_addr = 0;
    #1 chk("x0_read_rdy", id_ready, 1);
    step(); clr();
    #1 chk("x0_flush_pend", pend, 0);
    chk("x0_err", err, 0);

    // simultaneous inc/dec, then double decrement underflow
    id_valid = 1; id_we = 1; id_wd_addr = 3;
    step();
    wb_valid = 1; wb_addr = 3;
    #1 chk("sim_rdy", id_ready, 1);
    step(); clr();
    #1 chk("sim_cnt3", 32'(dut.cnt[3]), 1);
    chk("sim_err0", err, 0);
    wb_valid = 1; wb_addr = 3; kill_valid = 1; kill_addr = 3;
    step(); clr();
    #1 chk("sim_cnt3_zero", 32'(dut.cnt[3]), 0);
    chk("sim_err1", err, 1);
    step();
    chk("err_sticky", err, 1);

    // drain with two outstanding writes to x9
    id_valid = 1; id_we = 1; id_wd_addr = 9;
    step(); step(); clr();
    drain_req = 1; id_valid = 1;
    #1 chk("dr_rdy0", id_ready, 0);
    chk("dr_ack_idle", drain_ack, 0);
    step();
    wb_valid = 1; wb_addr = 9;
    #1 chk("dr_ack_drain", drain_ack, 0);
    step();
    chk("dr_ack_early", drain_ack, 0);
    step();
    wb_valid = 0;
    #1 chk("dr_ack_pulse", drain_ack, 1);
    chk("dr_rdy_ack", id_ready, 0);
    chk("dr_busy", busy, 0);
    step();
    chk("dr_ack_once", drain_ack, 0);
    chk("dr_rdy_wait", id_ready, 0);
    step();
    chk("dr_ack_wait", drain_ack, 0);
    drain_req = 0;
    #1 chk("dr_rdy_wait_rel", id_ready, 0);
    step();
    chk("dr_rdy_idle", id_ready, 1);

    // drain when already empty: ack two cycles after rise
    drain_req = 1;
    step();
    chk("dre_ack_c1", drain_ack, 0);
    step();
    chk("dre_ack_c2", drain_ack, 1);
    drain_req = 0;
    step();
    chk("dre_ack_c3", drain_ack, 0);
    step();
    chk("dre_rdy", id_ready, 1);

    // drain abandoned while waiting
    id_valid = 1; id_we = 1; id_wd_addr = 10;
    step(); clr();
    drain_req = 1;
    step(); step();
    chk("dra_no_ack", drain_ack, 0);
    drain_req = 0;
    step();
    chk("dra_rdy", id_ready, 1);
    chk("dra_ack", drain_ack, 0);
    wb_valid = 1; wb_addr = 10;
    step(); clr();
    #1 chk("dra_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
